// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one shared n-bit ALU: round-robin grant,
// opcode decode, single in-flight operation and a held response.
module alu_share_ctrl #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic         alu_ainv,
  output logic         alu_binv,
  output logic         alu_cin,
  output logic [1:0]   alu_select,
  input  logic [n-1:0] alu_result,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_err
);

  // state | meaning
  // IDLE  | no operation held; may grant one requester this cycle
  // EXEC  | captured operands on the ALU; result sampled at end of cycle
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_q;
  logic [2:0]   op_q;
  logic [n-1:0] a_q, b_q;
  logic         id_q;
  logic [n-1:0] res_q;
  logic         cout_q;
  logic         err_q;

  logic         grant;
  logic         gnt_id;
  logic [5:0]   ctrl;

  // {illegal, ainv, binv, cin, select}; illegal codes drive the AND setting
  function automatic logic [5:0] decode(input logic [2:0] op);
    logic [5:0] d;
    d = 6'b000000;
    case (op)
      3'b000:  d = 6'b000000;
      3'b001:  d = 6'b000001;
      3'b010:  d = 6'b000010;
      3'b011:  d = 6'b001110;
      3'b100:  d = 6'b001111;
      3'b101:  d = 6'b011000;
      default: d = 6'b100000;
    endcase
    return d;
  endfunction

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          grant   = 1'b1;
          gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = grant & ~gnt_id;
  assign req1_ready = grant &  gnt_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        op_q   <= gnt_id ? req1_op : req0_op;
        a_q    <= gnt_id ? req1_a  : req0_a;
        b_q    <= gnt_id ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        err_q  <= ctrl[5];
        res_q  <= ctrl[5] ? '0 : alu_result;
        cout_q <= ctrl[5] ? 1'b0 : alu_cout;
      end
    end
  end

  // ALU port is quiet while idle so the shared unit sees no stray activity
  always_comb begin
    ctrl       = decode(op_q);
    alu_a      = '0;
    alu_b      = '0;
    alu_ainv   = 1'b0;
    alu_binv   = 1'b0;
    alu_cin    = 1'b0;
    alu_select = 2'b00;
    if (state_q != IDLE) begin
      alu_a      = a_q;
      alu_b      = b_q;
      alu_ainv   = ctrl[4];
      alu_binv   = ctrl[3];
      alu_cin    = ctrl[2];
      alu_select = ctrl[1:0];
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_valid & id_q;
  assign rsp_result = rsp_valid ? res_q : '0;
  assign rsp_cout   = rsp_valid & cout_q;
  assign rsp_err    = rsp_valid & err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU stub, timeline model checked every cycle,
// and directed scenarios with literal expectations.
module tb_alu_share_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_ainv, alu_binv, alu_cin, alu_cout;
  logic [1:0]   alu_select;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
  logic [N-1:0] rsp_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } op_t;

  typedef struct {
    logic         id;
    logic [N-1:0] result;
    logic         cout;
    logic         err;
  } rsp_t;

  op_t  q0[$];
  op_t  q1[$];
  int   glog[$];
  rsp_t rlog[$];

  alu_share_ctrl #(.n(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(alu_ainv), .alu_binv(alu_binv),
    .alu_cin(alu_cin), .alu_select(alu_select),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // shared ALU stub: invert, add with carry-in, select
  logic [N-1:0] s_a, s_b;
  logic [N:0]   s_sum;
  always_comb begin
    s_a        = alu_ainv ? ~alu_a : alu_a;
    s_b        = alu_binv ? ~alu_b : alu_b;
    s_sum      = {1'b0, s_a} + {1'b0, s_b} + {{N{1'b0}}, alu_cin};
    alu_cout   = s_sum[N];
    alu_result = '0;
    case (alu_select)
      2'b00: alu_result = s_a & s_b;
      2'b01: alu_result = s_a | s_b;
      2'b10: alu_result = s_sum[N-1:0];
      2'b11: alu_result = {{(N-1){1'b0}}, s_sum[N-1]};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {cout, result} of an operation as the requester sees it
  function automatic logic [N:0] exp_out(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] add, sub, nadd;
    add  = {1'b0, a} + {1'b0, b};
    sub  = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
    nadd = {1'b0, ~a} + {1'b0, ~b};
    case (op)
      3'd0: return {add[N], a & b};
      3'd1: return {add[N], a | b};
      3'd2: return add;
      3'd3: return sub;
      3'd4: return {sub[N], {(N-1){1'b0}}, sub[N-1]};
      3'd5: return {nadd[N], ~(a | b)};
      default: return '0;
    endcase
  endfunction

  // {ainv, binv, cin, select} from the opcode table
  function automatic logic [4:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0: return 5'b00000;
      3'd1: return 5'b00001;
      3'd2: return 5'b00010;
      3'd3: return 5'b01110;
      3'd4: return 5'b01111;
      3'd5: return 5'b11000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic all_zero();
    return ({req0_ready, req1_ready, alu_a, alu_b, alu_ainv, alu_binv, alu_cin,
             alu_select, rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err} == '0);
  endfunction

  // model: one op in flight; age 1 = operands on ALU, age 2 = response up
  initial begin
    logic         m_busy, m_last, m_id, g, gid, e_valid;
    int           m_age;
    logic [2:0]   m_op;
    logic [N-1:0] m_a, m_b;
    logic [N:0]   e;
    m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_age = 0;
    m_op = '0; m_a = '0; m_b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs_zero", 64'(all_zero()), 64'd1);
        m_busy = 1'b0;
        m_last = 1'b1;
      end else begin
        g   = 1'b0;
        gid = 1'b0;
        if (!m_busy && (req0_valid || req1_valid)) begin
          g   = 1'b1;
          gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
        end
        e_valid = m_busy && (m_age >= 2);
        chk("req0_ready", 64'(req0_ready), 64'(g && !gid));
        chk("req1_ready", 64'(req1_ready), 64'(g && gid));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
        chk("alu_a", 64'(alu_a), m_busy ? 64'(m_a) : 64'd0);
        chk("alu_b", 64'(alu_b), m_busy ? 64'(m_b) : 64'd0);
        chk("alu_ctrl", 64'({alu_ainv, alu_binv, alu_cin, alu_select}),
            m_busy ? 64'(exp_ctrl(m_op)) : 64'd0);
        if (e_valid) begin
          e = exp_out(m_op, m_a, m_b);
          chk("rsp_id", 64'(rsp_id), 64'(m_id));
          chk("rsp_result", 64'(rsp_result), 64'(e[N-1:0]));
          chk("rsp_cout", 64'(rsp_cout), 64'(e[N]));
          chk("rsp_err", 64'(rsp_err), 64'(m_op[2] & m_op[1]));
        end
        if (req0_ready) glog.push_back(0);
        if (req1_ready) glog.push_back(1);
        if (rsp_valid && rsp_ready)
          rlog.push_back('{id: rsp_id, result: rsp_result, cout: rsp_cout, err: rsp_err});
        if (g) begin
          m_busy = 1'b1; m_age = 1; m_last = gid; m_id = gid;
          m_op = gid ? req1_op : req0_op;
          m_a  = gid ? req1_a  : req0_a;
          m_b  = gid ? req1_b  : req0_b;
        end else if (m_busy) begin
          if (e_valid && rsp_ready) m_busy = 1'b0;
          else if (m_age < 2) m_age++;
        end
      end
    end
  end

  // requester drivers: hold valid until granted, then present the next queued op
  initial begin
    logic gnt;
    op_t  t;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    forever begin
      @(negedge clk); gnt = req0_ready;
      @(posedge clk); #1;
      if (gnt) req0_valid = 1'b0;
      if (!req0_valid && q0.size() > 0) begin
        t = q0.pop_front();
        req0_op = t.op; req0_a = t.a; req0_b = t.b; req0_valid = 1'b1;
      end
    end
  end

  initial begin
    logic gnt;
    op_t  t;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    forever begin
      @(negedge clk); gnt = req1_ready;
      @(posedge clk); #1;
      if (gnt) req1_valid = 1'b0;
      if (!req1_valid && q1.size() > 0) begin
        t = q1.pop_front();
        req1_op = t.op; req1_a = t.a; req1_b = t.b; req1_valid = 1'b1;
      end
    end
  end

  task automatic wait_resp(input int target, input string nm);
    int k = 0;
    while (rlog.size() < target && k < 60) begin
      @(negedge clk); #1; k++;
    end
    chk(nm, 64'(rlog.size()), 64'(target));
  endtask

  task automatic wait_grant(input int target, input string nm);
    int k = 0;
    while (glog.size() < target && k < 60) begin
      @(negedge clk); #1; k++;
    end
    chk(nm, 64'(glog.size()), 64'(target));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("reset_async_zero", 64'(all_zero()), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int gb, rb;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    #1 chk("reset_t0_zero", 64'(all_zero()), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // lone ADD from req0: grant at T, response at T+2
    q0.push_back('{op: 3'd2, a: 32'd5, b: 32'd7});
    wait_grant(1, "t1_grant_seen");
    chk("t1_grant_id", 64'(glog[0]), 64'd0);
    chk("t1_ready_T", 64'(req0_ready), 64'd1);
    @(negedge clk); #1;
    chk("t1_valid_T1", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    chk("t1_valid_T2", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd12);
    chk("t1_cout", 64'(rsp_cout), 64'd0);
    wait_resp(1, "t1_resp_count");

    // tie from reset: req0 wins first, then req1
    do_reset();
    gb = glog.size(); rb = rlog.size();
    q0.push_back('{op: 3'd3, a: 32'd3, b: 32'd5});
    q1.push_back('{op: 3'd0, a: 32'h0000FF00, b: 32'h00000FF0});
    wait_resp(rb + 2, "t2_resp_count");
    chk("t2_first_grant", 64'(glog[gb]), 64'd0);
    chk("t2_second_grant", 64'(glog[gb+1]), 64'd1);
    chk("t2_r0_id", 64'(rlog[rb].id), 64'd0);
    chk("t2_r0_result", 64'(rlog[rb].result), 64'hFFFFFFFE);
    chk("t2_r0_cout", 64'(rlog[rb].cout), 64'd0);
    chk("t2_r1_id", 64'(rlog[rb+1].id), 64'd1);
    chk("t2_r1_result", 64'(rlog[rb+1].result), 64'h00000F00);

    // both valid continuously: strict alternation
    gb = glog.size(); rb = rlog.size();
    q0.push_back('{op: 3'd1, a: 32'h00F0, b: 32'h0F00});
    q0.push_back('{op: 3'd4, a: 32'd2, b: 32'd9});
    q1.push_back('{op: 3'd5, a: 32'h0000FFFF, b: 32'h00FF0000});
    q1.push_back('{op: 3'd2, a: 32'd40, b: 32'd2});
    wait_resp(rb + 4, "t3_resp_count");
    for (int i = 0; i < 4; i++) chk("t3_alternate", 64'(glog[gb+i]), 64'(i % 2));
    chk("t3_slt_result", 64'(rlog[rb+2].result), 64'd1);
    chk("t3_nor_result", 64'(rlog[rb+1].result), 64'hFF000000);

    // back-pressure: response held, competing request not granted
    @(posedge clk); #1 rsp_ready = 1'b0;
    rb = rlog.size(); gb = glog.size();
    q0.push_back('{op: 3'd2, a: 32'd100, b: 32'd200});
    begin
      int k = 0;
      while (!rsp_valid && k < 20) begin @(negedge clk); #1; k++; end
    end
    chk("t4_valid_up", 64'(rsp_valid), 64'd1);
    q1.push_back('{op: 3'd1, a: 32'h1, b: 32'h2});
    repeat (5) begin
      @(negedge clk); #1;
      chk("t4_hold_result", 64'(rsp_result), 64'd300);
      chk("t4_hold_r1_ready", 64'(req1_ready), 64'd0);
    end
    chk("t4_no_early_resp", 64'(rlog.size()), 64'(rb));
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("t4_handshake_no_grant", 64'(req1_ready), 64'd0);
    chk("t4_one_resp", 64'(rlog.size()), 64'(rb + 1));
    wait_resp(rb + 2, "t4_followup_resp");
    chk("t4_followup_id", 64'(rlog[rb+1].id), 64'd1);

    // illegal opcode and carry-out wrap
    rb = rlog.size();
    q1.push_back('{op: 3'd7, a: 32'h1234, b: 32'd5});
    wait_resp(rb + 1, "t5_illegal_resp");
    chk("t5_err", 64'(rlog[rb].err), 64'd1);
    chk("t5_result", 64'(rlog[rb].result), 64'd0);
    chk("t5_cout", 64'(rlog[rb].cout), 64'd0);
    q0.push_back('{op: 3'd2, a: 32'hFFFFFFFF, b: 32'd1});
    wait_resp(rb + 2, "t5_wrap_resp");
    chk("t5_wrap_result", 64'(rlog[rb+1].result), 64'd0);
    chk("t5_wrap_cout", 64'(rlog[rb+1].cout), 64'd1);
    chk("t5_wrap_err", 64'(rlog[rb+1].err), 64'd0);

    // reset during EXEC discards the operation
    gb = glog.size(); rb = rlog.size();
    q0.push_back('{op: 3'd2, a: 32'd1, b: 32'd2});
    wait_grant(gb + 1, "t6_grant");
    @(posedge clk); #1;
    chk("t6_in_exec", 64'(alu_a), 64'd1);
    rst_n = 1'b0;
    #1 chk("t6_reset_zero", 64'(all_zero()), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin @(negedge clk); #1; end
    chk("t6_no_resp", 64'(rlog.size()), 64'(rb));
    q1.push_back('{op: 3'd1, a: 32'h000000F0, b: 32'h0000000F});
    wait_resp(rb + 1, "t6_after_resp");
    chk("t6_after_id", 64'(rlog[rb].id), 64'd1);
    chk("t6_after_result", 64'(rlog[rb].result), 64'hFF);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
